// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS7 link-test checker.
// PRBS7_PATTERN is one full period of x^7+x^6+1 from an all-ones seed, identical to the source.
package prbs_pkg;

  localparam int PRBS_WORD_W = 16;
  localparam int PRBS7_LEN   = 127;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } prbs_chk_state_t;

  // Unrolls b[n+7] = b[n] ^ b[n+1] over one period; evaluated at elaboration only.
  function automatic logic [PRBS7_LEN-1:0] prbs7_gen();
    logic [PRBS7_LEN-1:0] p;
    p      = '0;
    p[6:0] = 7'h7f;
    for (int n = 0; n < PRBS7_LEN - 7; n++) begin
      p[n+7] = p[n] ^ p[n+1];
    end
    return p;
  endfunction

  localparam logic [PRBS7_LEN-1:0] PRBS7_PATTERN = prbs7_gen();

endpackage

// File: rtl/prbs_popcount16.sv
// Combinational population count of a 16-bit error vector (0..16).
module prbs_popcount16
  import prbs_pkg::*;
(
  input  logic [PRBS_WORD_W-1:0] din,
  output logic [4:0]             cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < PRBS_WORD_W; i++) begin
      cnt = cnt + 5'(din[i]);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS7 checker: hunts all 127 phases, locks, and counts bit/word errors.
// Defining PRBS_CHK_ERR_INJ_EN adds the inj_err self-test port (inverts rx_data[0] before compare).
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                   clk1280,
  input  logic                   rst_n,
  input  logic                   data_valid,
  input  logic [PRBS_WORD_W-1:0] rx_data,
  input  logic                   clr,
`ifdef PRBS_CHK_ERR_INJ_EN
  input  logic                   inj_err,
`endif
  output logic                   locked,
  output logic                   err_flag,
  output logic [CNT_W-1:0]       err_bit_cnt,
  output logic [CNT_W-1:0]       err_word_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);
  localparam int SUM_W   = ((CNT_W > 5) ? CNT_W : 5) + 1;

  prbs_chk_state_t        state;
  logic [PRBS7_LEN-1:0]   exp_pat;
  logic [PRBS7_LEN-1:0]   pat_step;
  logic [PRBS7_LEN-1:0]   pat_slip;
  logic [MATCH_W-1:0]     match_run;
  logic [MISS_W-1:0]      miss_run;
  logic [PRBS_WORD_W-1:0] rx_cmp;
  logic [PRBS_WORD_W-1:0] err_vec;
  logic [4:0]             nerr;
  logic                   word_match;
  logic                   err_hit;
  logic [SUM_W-1:0]       bit_sum;
  logic [CNT_W-1:0]       bit_next;
  logic [CNT_W-1:0]       word_next;

`ifdef PRBS_CHK_ERR_INJ_EN
  assign rx_cmp = rx_data ^ {{(PRBS_WORD_W-1){1'b0}}, inj_err};
`else
  assign rx_cmp = rx_data;
`endif

  assign err_vec    = rx_cmp ^ exp_pat[31:16];
  assign word_match = (err_vec == '0);

  prbs_popcount16 u_popcount (
    .din (err_vec),
    .cnt (nerr)
  );

  // Normal advance is 32 bits per beat; a slip takes one extra bit to try the next phase.
  assign pat_step = {exp_pat[31:0], exp_pat[PRBS7_LEN-1:32]};
  assign pat_slip = {exp_pat[32:0], exp_pat[PRBS7_LEN-1:33]};

  assign err_hit   = data_valid && (state == LOCKED) && !word_match;
  assign bit_sum   = SUM_W'(err_bit_cnt) + SUM_W'(nerr);
  assign bit_next  = (bit_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : bit_sum[CNT_W-1:0];
  assign word_next = (&err_word_cnt) ? err_word_cnt : err_word_cnt + CNT_W'(1);

  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      exp_pat   <= PRBS7_PATTERN;
      match_run <= '0;
      miss_run  <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      err_flag <= 1'b0;
      if (data_valid) begin
        case (state)
          HUNT: begin
            if (word_match) begin
              exp_pat <= pat_step;
              if (LOCK_CNT <= 1) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_run <= '0;
                miss_run  <= '0;
              end else begin
                state     <= VERIFY;
                match_run <= MATCH_W'(1);
              end
            end else begin
              exp_pat <= pat_slip;
            end
          end
          VERIFY: begin
            if (word_match) begin
              exp_pat <= pat_step;
              if (match_run >= MATCH_W'(LOCK_CNT - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_run <= '0;
                miss_run  <= '0;
              end else begin
                match_run <= match_run + MATCH_W'(1);
              end
            end else begin
              state     <= HUNT;
              match_run <= '0;
              exp_pat   <= pat_slip;
            end
          end
          LOCKED: begin
            // Never slip once locked, so a burst of bad words leaves the phase intact for relock.
            exp_pat <= pat_step;
            if (word_match) begin
              miss_run <= '0;
            end else begin
              err_flag <= 1'b1;
              if (miss_run >= MISS_W'(UNLOCK_CNT - 1)) begin
                state     <= HUNT;
                locked    <= 1'b0;
                miss_run  <= '0;
                match_run <= '0;
              end else begin
                miss_run <= miss_run + MISS_W'(1);
              end
            end
          end
          default: begin
            state     <= HUNT;
            locked    <= 1'b0;
            match_run <= '0;
            miss_run  <= '0;
          end
        endcase
      end
    end
  end

  // clr has priority, so an error landing on the clear cycle is dropped.
  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      err_bit_cnt  <= '0;
      err_word_cnt <= '0;
    end else if (clr) begin
      err_bit_cnt  <= '0;
      err_word_cnt <= '0;
    end else if (err_hit) begin
      err_bit_cnt  <= bit_next;
      err_word_cnt <= word_next;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: 32-bit and 4-bit counter instances share one stimulus stream
// and are checked against a scoreboard built from an independent PRBS7 source model.
module tb_prbs_checker;

  logic        clk1280 = 1'b0;
  logic        rst_n;
  logic        data_valid;
  logic [15:0] rx_data;
  logic        clr;
`ifdef PRBS_CHK_ERR_INJ_EN
  logic        inj_err;
`endif

  logic        locked,    err_flag;
  logic [31:0] err_bit_cnt, err_word_cnt;
  logic        locked4,   err_flag4;
  logic [3:0]  err_bit_cnt4, err_word_cnt4;

  logic [126:0] pat;
  logic [126:0] src;
  longint       acc_bits;
  longint       acc_words;
  int           total = 0;
  int           bad   = 0;
  string        tag;

  typedef struct {
    logic   chk_lock;
    logic   locked;
    logic   flag;
    longint bits;
    longint words;
  } exp_t;

  exp_t sb[$];

  prbs_checker dut (
    .clk1280      (clk1280),
    .rst_n        (rst_n),
    .data_valid   (data_valid),
    .rx_data      (rx_data),
    .clr          (clr),
`ifdef PRBS_CHK_ERR_INJ_EN
    .inj_err      (inj_err),
`endif
    .locked       (locked),
    .err_flag     (err_flag),
    .err_bit_cnt  (err_bit_cnt),
    .err_word_cnt (err_word_cnt)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk1280      (clk1280),
    .rst_n        (rst_n),
    .data_valid   (data_valid),
    .rx_data      (rx_data),
    .clr          (clr),
`ifdef PRBS_CHK_ERR_INJ_EN
    .inj_err      (inj_err),
`endif
    .locked       (locked4),
    .err_flag     (err_flag4),
    .err_bit_cnt  (err_bit_cnt4),
    .err_word_cnt (err_word_cnt4)
  );

  always #5 clk1280 = ~clk1280;

  // Reference PRBS7 period built straight from the recurrence, all-ones seed.
  function automatic logic [126:0] gen_pat();
    logic [126:0] p;
    p = '0;
    for (int i = 0; i < 7; i++) p[i] = 1'b1;
    for (int n = 0; n < 120; n++) p[n+7] = p[n] ^ p[n+1];
    return p;
  endfunction

  function automatic longint sat4(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic src_step();
    src = {src[31:0], src[126:32]};
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s/%s got=%0h want=%0h", tag, name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c, input exp_t e);
    @(negedge clk1280);
    data_valid = v;
    rx_data    = d;
    clr        = c;
    sb.push_back(e);
    @(posedge clk1280);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    e = sb.pop_front();
    if (e.chk_lock) begin
      cmp("locked",  64'(locked),  64'(e.locked));
      cmp("locked4", 64'(locked4), 64'(e.locked));
    end
    cmp("err_flag",      64'(err_flag),      64'(e.flag));
    cmp("err_flag4",     64'(err_flag4),     64'(e.flag));
    cmp("err_bit_cnt",   64'(err_bit_cnt),   64'(e.bits));
    cmp("err_word_cnt",  64'(err_word_cnt),  64'(e.words));
    cmp("err_bit_cnt4",  64'(err_bit_cnt4),  64'(sat4(e.bits)));
    cmp("err_word_cnt4", 64'(err_word_cnt4), 64'(sat4(e.words)));
  endtask

  // One clock of stimulus; error bits are counted against the true source word of this beat.
  task automatic beat(input logic v, input logic [15:0] d, input logic c,
                      input logic chk_lock, input logic lock_exp, input logic flag_exp);
    exp_t e;
    if (c) begin
      acc_bits  = 0;
      acc_words = 0;
    end else if (flag_exp) begin
      acc_bits  += longint'($countones(d ^ src[31:16]));
      acc_words += 1;
    end
    e.chk_lock = chk_lock;
    e.locked   = lock_exp;
    e.flag     = flag_exp;
    e.bits     = acc_bits;
    e.words    = acc_words;
    applyStimulus(v, d, c, e);
    checkOutput();
    if (v) src_step();
  endtask

  task automatic doReset();
    acc_bits  = 0;
    acc_words = 0;
    @(negedge clk1280);
    rst_n = 1'b0;
    beat(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk1280);
    rst_n = 1'b1;
  endtask

  initial begin
    int nvalid;
    int d;
    logic v;

    rst_n      = 1'b0;
    data_valid = 1'b0;
    rx_data    = '0;
    clr        = 1'b0;
`ifdef PRBS_CHK_ERR_INJ_EN
    inj_err    = 1'b0;
`endif
    pat = gen_pat();

    // 1: phase-0 stream from reset locks after beat 8, then stays clean.
    tag = "reset";
    doReset();
    tag = "phase0";
    src = pat;
    for (int k = 1; k <= 1000; k++)
      beat(1'b1, src[31:16], 1'b0, 1'b1, k >= 8, 1'b0);

    // 2: phase 50 needs 50 slips then 8 matches, so lock follows beat 58.
    tag = "phase50";
    doReset();
    src = {pat[49:0], pat[126:50]};
    for (int k = 1; k <= 200; k++)
      beat(1'b1, src[31:16], 1'b0, 1'b1, k >= 58, 1'b0);

    // 3: three flipped bits on a single locked beat.
    tag = "flip3";
    beat(1'b1, src[31:16] ^ 16'h8021, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++)
      beat(1'b1, src[31:16], 1'b0, 1'b1, 1'b1, 1'b0);

    // 4: four zero words drop lock; phase is preserved so relock takes exactly 8 beats.
    tag = "zeros";
    for (int k = 1; k <= 4; k++)
      beat(1'b1, 16'h0000, 1'b0, 1'b1, k < 4, 1'b1);
    tag = "relock";
    for (int k = 1; k <= 20; k++)
      beat(1'b1, src[31:16], 1'b0, 1'b1, k >= 8, 1'b0);

    // 5: clear, then 16 fully inverted words interleaved with clean ones to stay locked.
    tag = "saturate";
    beat(1'b1, src[31:16], 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      beat(1'b1, ~src[31:16], 1'b0, 1'b1, 1'b1, 1'b1);
      beat(1'b1, src[31:16], 1'b0, 1'b1, 1'b1, 1'b0);
    end
    tag = "clr_vs_err";
    beat(1'b1, ~src[31:16], 1'b1, 1'b1, 1'b1, 1'b1);
    beat(1'b1, src[31:16], 1'b0, 1'b1, 1'b1, 1'b0);

    // 6: random 50% valid; invalid beats carry garbage and must be ignored.
    tag = "gapped";
    doReset();
    src    = pat;
    nvalid = 0;
    for (int k = 0; k < 200; k++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        nvalid++;
        beat(1'b1, src[31:16], 1'b0, 1'b1, nvalid >= 8, 1'b0);
      end else begin
        beat(1'b0, 16'($urandom), 1'b0, 1'b1, nvalid >= 8, 1'b0);
      end
    end
    for (int k = 0; k < 10; k++) begin
      nvalid++;
      beat(1'b1, src[31:16], 1'b0, 1'b1, 1'b1, 1'b0);
    end

    tag = "midlock_reset";
    doReset();
    d = (32 * nvalid) % 127;
    tag = "rehunt";
    for (int k = 1; k <= d + 12; k++)
      beat(1'b1, src[31:16], 1'b0, 1'b1, k >= d + 8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
